// File: rtl/keychain_pkg.sv
// Shared definitions for the keychain arithmetic blocks: the mod_exp
// sequencer state encoding and the modular multiplier latency.
package keychain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REDUCE,
    MUL,
    SQR,
    NEXT,
    DONE
  } modexp_state_e;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int MODMUL_LATENCY = 2 * DEFAULT_WIDTH + 2;

  // Cycles from the request cycle to the valid pulse for a given width.
  function automatic int modmul_latency(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/mod_mult.sv
// Modular multiplier: latches a, b, m; forms a*b in one cycle, then reduces
// it MSB-first by restoring shift-subtract, one product bit per cycle.
module mod_mult
  import keychain_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] product_out,
  output logic             busy_out,
  output logic             valid_out
);

  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = modmul_latency(WIDTH) - 2;
  localparam int CW    = $clog2(STEPS + 1);

  logic [WIDTH-1:0] a_q, b_q, m_q, r_q;
  logic [PW-1:0]    prod_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, load_q, last_busy_q;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_d;

  // r stays below m, so 2r+bit fits in WIDTH+1 bits and one subtract restores it.
  always_comb begin
    r_sh = {r_q, prod_q[PW-1]};
    r_d  = r_sh[WIDTH-1:0];
    if (r_sh >= {1'b0, m_q}) r_d = r_sh[WIDTH-1:0] - m_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      last_busy_q <= 1'b0;
    end else begin
      last_busy_q <= busy_q;
      if (!busy_q) begin
        if (ready_in) begin
          a_q    <= a_in;
          b_q    <= b_in;
          m_q    <= modulus_in;
          busy_q <= 1'b1;
          load_q <= 1'b1;
        end
      end else if (load_q) begin
        prod_q <= PW'(a_q) * PW'(b_q);
        r_q    <= '0;
        cnt_q  <= CW'(STEPS);
        load_q <= 1'b0;
      end else begin
        r_q    <= r_d;
        prod_q <= {prod_q[PW-2:0], 1'b0};
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) busy_q <= 1'b0;
      end
    end
  end

  assign product_out = r_q;
  assign busy_out    = busy_q;
  assign valid_out   = last_busy_q && !busy_q;

endmodule

// File: rtl/mod_exp.sv
// Modular exponentiation, right-to-left square-and-multiply, sequencing a
// single mod_mult through the ready/busy/valid handshake.
module mod_exp
  import keychain_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] base_in,
  input  logic [WIDTH-1:0] exponent_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] result_out,
  output logic             error_out,
  output logic             busy_out,
  output logic             valid_out
);

  modexp_state_e    state_q;
  logic [WIDTH-1:0] b_q, e_q, m_q, acc_q, result_q;
  logic             error_q, busy_q, last_busy_q, req_q, mul_done_q;

  logic [WIDTH-1:0] mm_a, mm_b, mm_prod;
  logic             mm_busy, mm_valid;

  // REDUCE multiplies the raw base by one so the loop always sees b < m.
  always_comb begin
    mm_a = b_q;
    mm_b = WIDTH'(1);
    case (state_q)
      MUL: begin
        mm_a = acc_q;
        mm_b = b_q;
      end
      SQR:     mm_b = b_q;
      default: ;
    endcase
  end

  mod_mult #(.WIDTH(WIDTH)) u_mult (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .ready_in    (req_q),
    .a_in        (mm_a),
    .b_in        (mm_b),
    .modulus_in  (m_q),
    .product_out (mm_prod),
    .busy_out    (mm_busy),
    .valid_out   (mm_valid)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      b_q         <= '0;
      e_q         <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      last_busy_q <= 1'b0;
      req_q       <= 1'b0;
      mul_done_q  <= 1'b0;
    end else begin
      req_q       <= 1'b0;
      last_busy_q <= busy_q;
      unique case (state_q)
        IDLE: begin
          if (ready_in) begin
            b_q        <= base_in;
            e_q        <= exponent_in;
            m_q        <= modulus_in;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            mul_done_q <= 1'b0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (m_q == '0) begin
            acc_q   <= '0;
            state_q <= DONE;
          end else begin
            acc_q   <= (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
            req_q   <= 1'b1;
            state_q <= REDUCE;
          end
        end
        REDUCE, SQR: begin
          if (mm_valid) begin
            b_q     <= mm_prod;
            state_q <= NEXT;
          end
        end
        MUL: begin
          if (mm_valid) begin
            acc_q      <= mm_prod;
            mul_done_q <= 1'b1;
            state_q    <= NEXT;
          end
        end
        // mul_done_q marks that the current low bit has already been multiplied in.
        NEXT: begin
          if (e_q == '0) begin
            state_q <= DONE;
          end else if (e_q[0] && !mul_done_q) begin
            req_q   <= 1'b1;
            state_q <= MUL;
          end else begin
            mul_done_q <= 1'b0;
            e_q        <= e_q >> 1;
            if ((e_q >> 1) != '0) begin
              req_q   <= 1'b1;
              state_q <= SQR;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          result_q <= acc_q;
          error_q  <= (m_q == '0);
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_out = result_q;
  assign error_out  = error_q;
  assign busy_out   = busy_q;
  assign valid_out  = last_busy_q && !busy_q;

endmodule
